mult_div_unit: RTL and testbench

//  Parametrised multicycle multiply/divide unit with HI/LO result registers, for the MIPS core datapath.

---
 rtl/mult_div_unit_pkg.sv | 39 +++
 rtl/mult_div_unit.sv | 155 +++++++++++++++
 tb/tb_mult_div_unit.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings used by Control,
// FSM state type and small op-decode helpers.
package mdu_pkg;

    localparam logic [2:0] MDU_MULT  = 3'd0;
    localparam logic [2:0] MDU_MULTU = 3'd1;
    localparam logic [2:0] MDU_DIV   = 3'd2;
    localparam logic [2:0] MDU_DIVU  = 3'd3;
    localparam logic [2:0] MDU_MTHI  = 3'd4;
    localparam logic [2:0] MDU_MTLO  = 3'd5;

    typedef enum logic [2:0] {
        OP_MULT  = MDU_MULT,
        OP_MULTU = MDU_MULTU,
        OP_DIV   = MDU_DIV,
        OP_DIVU  = MDU_DIVU,
        OP_MTHI  = MDU_MTHI,
        OP_MTLO  = MDU_MTLO
    } mdu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } mdu_state_t;

    function automatic logic op_is_arith(input logic [2:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

    function automatic logic op_is_div(input logic [2:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

    function automatic logic op_is_signed(input logic [2:0] op);
        return (op == MDU_MULT) || (op == MDU_DIV);
    endfunction

endpackage

// File: rtl/mult_div_unit.sv
// Multicycle multiply (shift-add) / divide (restoring) unit with HI/LO registers.
// Signed ops run on magnitudes; signs are reapplied in the single FIX cycle.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter bit DIV_EN = 1'b1
) (
    input  logic             Clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v, input logic en);
        return en ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v, input logic en);
        return en ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] v, input logic is_signed);
        return neg_w(v, is_signed && (v < 0));
    endfunction

    mdu_state_t         state, state_nxt;
    logic [CW-1:0]      count;
    logic               op_div, op_signed, sign_q, sign_r, dz_q, ill_q;
    logic [WIDTH-1:0]   opnd_q;
    logic [2*WIDTH-1:0] acc;

    logic               accept, start_div, start_signed, b_zero;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mul_sum, div_shift, div_diff;
    logic [2*WIDTH-1:0] mul_step, div_step, prod;
    logic [WIDTH-1:0]   fix_hi, fix_lo;

    assign start_div    = op_is_div(op);
    assign start_signed = op_is_signed(op);
    assign b_zero       = (b == '0);
    assign accept       = (state == IDLE) && start && op_is_arith(op);
    assign a_mag        = mag(a, start_signed);
    assign b_mag        = mag(b, start_signed);

    // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
    assign mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd_q} : '0);
    assign mul_step  = {mul_sum, acc[WIDTH-1:1]};
    assign div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, opnd_q};
    assign div_step  = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                       : {div_diff[WIDTH-1:0],  acc[WIDTH-2:0], 1'b1};
    assign prod      = neg_2w(acc, op_signed && sign_q);

    always_comb begin
        fix_hi = hi;
        fix_lo = lo;
        if (ill_q) begin
            fix_hi = hi;
        end else if (dz_q) begin
            fix_hi = acc[WIDTH-1:0];
            fix_lo = '1;
        end else if (op_div) begin
            fix_lo = neg_w(acc[WIDTH-1:0], op_signed && sign_q);
            fix_hi = neg_w(acc[2*WIDTH-1:WIDTH], op_signed && sign_r);
        end else begin
            fix_hi = prod[2*WIDTH-1:WIDTH];
            fix_lo = prod[WIDTH-1:0];
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = (start_div && (!DIV_EN || b_zero)) ? FIX : RUN;
            RUN:  if (count == LAST) state_nxt = FIX;
            FIX:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            count     <= '0;
            op_div    <= 1'b0;
            op_signed <= 1'b0;
            sign_q    <= 1'b0;
            sign_r    <= 1'b0;
            dz_q      <= 1'b0;
            ill_q     <= 1'b0;
            opnd_q    <= '0;
            acc       <= '0;
            hi        <= '0;
            lo        <= '0;
            done      <= 1'b0;
            div_zero  <= 1'b0;
        end else begin
            state    <= state_nxt;
            done     <= 1'b0;
            div_zero <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && op == MDU_MTHI) begin
                        hi <= a;
                    end else if (start && op == MDU_MTLO) begin
                        lo <= a;
                    end else if (accept) begin
                        op_div    <= start_div;
                        op_signed <= start_signed;
                        sign_q    <= a[WIDTH-1] ^ b[WIDTH-1];
                        sign_r    <= a[WIDTH-1];
                        dz_q      <= start_div && DIV_EN && b_zero;
                        ill_q     <= start_div && !DIV_EN;
                        count     <= '0;
                        // a divide by zero keeps the raw dividend so FIX can return it in HI
                        if (start_div) begin
                            opnd_q <= b_mag;
                            acc    <= {{WIDTH{1'b0}}, (b_zero ? a : a_mag)};
                        end else begin
                            opnd_q <= a_mag;
                            acc    <= {{WIDTH{1'b0}}, b_mag};
                        end
                    end
                end
                RUN: begin
                    count <= count + 1'b1;
                    acc   <= op_div ? div_step : mul_step;
                end
                FIX: begin
                    hi       <= fix_hi;
                    lo       <= fix_lo;
                    done     <= 1'b1;
                    div_zero <= dz_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: directed literal cases plus randomized ops, all checked
// every cycle against an op-level model (plain 64-bit arithmetic plus a latency countdown).
module tb_mult_div_unit;
    import mdu_pkg::*;

    localparam int W = 32;

    logic         Clk = 1'b0;
    logic         reset, start;
    logic [2:0]   op;
    logic [W-1:0] a, b;
    logic         busy, done, div_zero;
    logic [W-1:0] hi, lo;

    int checks   = 0;
    int failures = 0;

    mult_div_unit #(.WIDTH(W), .DIV_EN(1'b1)) dut (
        .Clk(Clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model_op(input logic [2:0] mop, input logic [W-1:0] ma, input logic [W-1:0] mb,
                                     output logic [W-1:0] rh, output logic [W-1:0] rl,
                                     output logic rdz, output int lat);
        logic signed [63:0] sa, sb, sq, sr;
        logic [63:0] ua, ub, p;
        sa  = {{32{ma[W-1]}}, ma};
        sb  = {{32{mb[W-1]}}, mb};
        ua  = {32'b0, ma};
        ub  = {32'b0, mb};
        rdz = 1'b0;
        lat = W + 1;
        p   = '0;
        if (mop == MDU_MULT) begin
            p = sa * sb;
            rh = p[63:32]; rl = p[31:0];
        end else if (mop == MDU_MULTU) begin
            p = ua * ub;
            rh = p[63:32]; rl = p[31:0];
        end else if (mb == '0) begin
            rh = ma; rl = '1; rdz = 1'b1; lat = 1;
        end else if (mop == MDU_DIV) begin
            sq = sa / sb; sr = sa % sb;
            rl = sq[31:0]; rh = sr[31:0];
        end else begin
            p = ua / ub; rl = p[31:0];
            p = ua % ub; rh = p[31:0];
        end
    endfunction

    // op-level model: an accepted op completes a fixed number of edges later
    logic [W-1:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
    logic         m_done = 1'b0, m_dz = 1'b0, p_dz = 1'b0;
    int           m_left = 0;

    always @(posedge Clk or posedge reset) begin
        if (reset) begin
            m_hi = '0; m_lo = '0; m_done = 1'b0; m_dz = 1'b0; m_left = 0;
        end else begin
            m_done = 1'b0;
            m_dz   = 1'b0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_hi = p_hi; m_lo = p_lo; m_done = 1'b1; m_dz = p_dz;
                end
            end else if (start) begin
                if (op == MDU_MTHI) m_hi = a;
                else if (op == MDU_MTLO) m_lo = a;
                else if (op_is_arith(op)) model_op(op, a, b, p_hi, p_lo, p_dz, m_left);
            end
        end
    end

    always @(negedge Clk) begin
        check("busy", busy, (m_left > 0));
        check("done", done, m_done);
        check("div_zero", div_zero, m_dz);
        check("hi", hi, m_hi);
        check("lo", lo, m_lo);
    end

    task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        @(negedge Clk);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge Clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int edges);
        edges = 1;
        while (!done && edges < 200) begin
            @(posedge Clk);
            #1;
            edges++;
        end
        check("done_seen", done, 1'b1);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0: return '0;
            1: return 32'h8000_0000;
            2: return '1;
            3: return W'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int e, n;
        reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
        repeat (3) @(negedge Clk);
        check("rst_busy", busy, 1'b0);
        check("rst_hi", hi, 32'h0);
        reset = 1'b0;

        issue(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(e);
        check("multu_latency", e, 34);
        check("multu_hi", hi, 32'hFFFF_FFFE);
        check("multu_lo", lo, 32'h0000_0001);

        issue(MDU_MULT, -32'sd7, 32'd3);
        wait_done(e);
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_lo", lo, 32'hFFFF_FFEB);

        issue(MDU_DIV, -32'sd7, 32'd2);
        wait_done(e);
        check("div_lo", lo, 32'hFFFF_FFFD);
        check("div_hi", hi, 32'hFFFF_FFFF);

        issue(MDU_DIVU, 32'd100, 32'd0);
        wait_done(e);
        check("divz_latency", e, 2);
        check("divz_flag", div_zero, 1'b1);
        check("divz_hi", hi, 32'd100);
        check("divz_lo", lo, 32'hFFFF_FFFF);

        issue(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(e);
        check("minneg1_lo", lo, 32'h8000_0000);
        check("minneg1_hi", hi, 32'h0);
        check("minneg1_flag", div_zero, 1'b0);

        // start held high through the whole op, next op swapped in on the done cycle
        @(negedge Clk);
        start = 1'b1; op = MDU_DIVU; a = 32'd50; b = 32'd7;
        @(posedge Clk);
        #1;
        wait_done(e);
        check("hold_lo", lo, 32'd7);
        check("hold_hi", hi, 32'd1);
        op = MDU_MULTU; a = 32'd3; b = 32'd5;
        @(posedge Clk);
        #1;
        start = 1'b0;
        check("accept_on_done", busy, 1'b1);
        wait_done(e);
        check("next_lo", lo, 32'd15);

        @(negedge Clk);
        start = 1'b1; op = MDU_MTHI; a = 32'h1234;
        @(negedge Clk);
        op = MDU_MTLO; a = 32'h5678;
        @(negedge Clk);
        start = 1'b0;
        check("mthi", hi, 32'h1234);
        check("mtlo", lo, 32'h5678);

        issue(MDU_MULT, 32'd123456, 32'd789);
        repeat (9) @(posedge Clk);
        #2;
        reset = 1'b1;
        #1;
        check("abort_busy", busy, 1'b0);
        check("abort_hi", hi, 32'h0);
        check("abort_lo", lo, 32'h0);
        @(negedge Clk);
        reset = 1'b0;
        issue(MDU_MULT, 32'd6, 32'd7);
        wait_done(e);
        check("after_reset_lo", lo, 32'd42);

        for (int i = 0; i < 150; i++) begin
            @(negedge Clk);
            start = 1'b1;
            op = 3'($urandom_range(0, 7));
            a = pick();
            b = pick();
            n = 0;
            do begin
                @(negedge Clk);
                n++;
                start = ($urandom_range(0, 3) == 0);
                op = 3'($urandom);
                a = $urandom;
                b = $urandom;
            end while (busy && n < 100);
            start = 1'b0;
            check("rand_idle", busy, 1'b0);
        end

        repeat (2) @(negedge Clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
